prog_loader: RTL and testbench

Boot-time program loader and run supervisor for the veri_Risc core. It accepts a byte stream over a valid/ready handshake and writes it into program memory from address 0. It then releases the CPU from reset and watches the CPU's halt output, flagging a timeout if halt never comes. While the CPU is held in reset, its mem_* outputs are muxed onto the memory write port at top level.

---
 rtl/prog_loader.sv | 137 +++++++++++++
 tb/tb_prog_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader and run supervisor for the veri_Risc core.
// Streams bytes into program memory from address 0, then releases the CPU from
// reset and watches for halt, flagging overflow or run timeout.
//
// Stream handshake: a byte transfers on a rising edge where in_valid and
// in_ready are both 1; in_ready is 1 exactly when the FSM is in LOAD, and the
// loader never stalls a presented byte while in LOAD.
module prog_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16,
    parameter int TIMEOUT    = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  cpu_rst,
    input  logic                  cpu_halt,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic [CNT_WIDTH-1:0]  cycles,
    output logic [2:0]            o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FLUSH  = 3'd2,
        S_RUN    = 3'd3,
        S_HALTED = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = {ADDR_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [1:0]            ERR_NONE     = 2'b00;
    localparam logic [1:0]            ERR_OVERFLOW = 2'b01;
    localparam logic [1:0]            ERR_TIMEOUT  = 2'b10;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_mem_wr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic [ADDR_WIDTH:0]   r_words;
    logic [CNT_WIDTH-1:0]  r_cycles;
    logic [1:0]            r_err_code;
    logic                  w_accept;

    // A byte is taken only in LOAD, where in_ready is high.
    assign w_accept = (r_state == S_LOAD) && in_valid;

    // Main FSM: loading, flush, run supervision and error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_words    <= '0;
            r_cycles   <= '0;
            r_err_code <= ERR_NONE;
        end else begin
            // The write strobe is a single-cycle pulse after each accepted byte.
            r_mem_wr <= 1'b0;
            case (r_state)
                S_IDLE, S_HALTED, S_ERROR: begin
                    if (load_start) begin
                        r_state    <= S_LOAD;
                        r_ptr      <= '0;
                        r_words    <= '0;
                        r_cycles   <= '0;
                        r_err_code <= ERR_NONE;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_mem_wr   <= 1'b1;
                        r_mem_addr <= r_ptr;
                        r_mem_data <= in_data;
                        r_ptr      <= r_ptr + 1'b1;
                        r_words    <= r_words + 1'b1;
                        // in_last wins even on the top address: that load fits exactly.
                        if (in_last) begin
                            r_state <= S_FLUSH;
                        end else if (r_ptr == LAST_ADDR) begin
                            r_state    <= S_ERROR;
                            r_err_code <= ERR_OVERFLOW;
                        end
                    end
                end
                S_FLUSH: begin
                    // The final byte's write pulse lands here; the CPU starts next cycle.
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    // Halt takes priority over a coincident timeout.
                    if (cpu_halt) begin
                        r_state <= S_HALTED;
                    end else if (r_cycles == TIMEOUT_LAST) begin
                        r_state    <= S_ERROR;
                        r_err_code <= ERR_TIMEOUT;
                    end else begin
                        r_cycles <= r_cycles + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = (r_state == S_LOAD);
    // The CPU stays out of reset while halted so its final state can be inspected.
    assign cpu_rst      = !((r_state == S_RUN) || (r_state == S_HALTED));
    assign done         = (r_state == S_HALTED);
    assign error        = (r_state == S_ERROR);
    assign mem_wr       = r_mem_wr;
    assign mem_addr     = r_mem_addr;
    assign mem_data     = r_mem_data;
    assign err_code     = r_err_code;
    assign words_loaded = r_words;
    assign cycles       = r_cycles;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader with a write scoreboard.
module tb_prog_loader;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int TO = 20;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_FLUSH  = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;

  logic          clk;
  logic          rst;
  logic          load_start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          cpu_rst;
  logic          cpu_halt;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [AW:0]   words_loaded;
  logic [CW-1:0] cycles;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  // expected writes: {addr, data}
  logic [AW+DW-1:0] exp_q[$];

  prog_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .cpu_rst     (cpu_rst),
    .cpu_halt    (cpu_halt),
    .done        (done),
    .error       (error),
    .err_code    (err_code),
    .words_loaded(words_loaded),
    .cycles      (cycles),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: inputs were set at a falling edge, come back at the next falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    step();
  endtask

  // drive one byte that the loader is known to accept, record the expected write
  task automatic send_byte(input logic [DW-1:0] d, input logic last, input logic [AW-1:0] a);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    exp_q.push_back({a, d});
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  // scoreboard: every write strobe must match the next expected write
  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL wr_spurious observed addr=%0h data=%0h expected no write", mem_addr, mem_data);
      end
      if (exp_q.size() != 0) chk("wr_addr_data", {mem_addr, mem_data}, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; cpu_halt = 1'b0;
    @(negedge clk);
    step();
    // reset state
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_words", words_loaded, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_err", err_code, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;
    // halt outside RUN is ignored
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    chk("idle_halt_ignored", dbg_state, ST_IDLE);

    // 1: back-to-back load of 4 bytes
    start_load();
    chk("t1_load", dbg_state, ST_LOAD);
    chk("t1_in_ready", in_ready, 1);
    send_byte(8'hA0, 1'b0, 5'd0);
    send_byte(8'hA1, 1'b0, 5'd1);
    send_byte(8'hA2, 1'b0, 5'd2);
    chk("t1_words3", words_loaded, 3);
    send_byte(8'hE0, 1'b1, 5'd3);
    chk("t1_flush", dbg_state, ST_FLUSH);
    chk("t1_flush_cpu_rst", cpu_rst, 1);
    chk("t1_flush_in_ready", in_ready, 0);
    step();
    chk("t1_run", dbg_state, ST_RUN);
    chk("t1_run_cpu_rst", cpu_rst, 0);
    chk("t1_words4", words_loaded, 4);
    chk("t1_cycles0", cycles, 0);
    chk("t1_q_drained", exp_q.size(), 0);

    // 4: halt on the 10th RUN cycle
    repeat (9) step();
    chk("t4_cycles9_run", cycles, 9);
    chk("t4_still_run", dbg_state, ST_RUN);
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    chk("t4_halted", dbg_state, ST_HALTED);
    chk("t4_done", done, 1);
    chk("t4_cycles", cycles, 9);
    chk("t4_cpu_rst", cpu_rst, 0);
    step();
    step();
    chk("t4_cycles_held", cycles, 9);
    chk("t4_err_none", err_code, 0);

    // 2: gapped stream, restarted from HALTED
    start_load();
    chk("t2_load", dbg_state, ST_LOAD);
    chk("t2_cycles_clr", cycles, 0);
    chk("t2_words_clr", words_loaded, 0);
    send_byte(8'hB0, 1'b0, 5'd0);
    idle_cycle();
    idle_cycle();
    send_byte(8'hB1, 1'b0, 5'd1);
    idle_cycle();
    chk("t2_words2", words_loaded, 2);
    send_byte(8'hB2, 1'b0, 5'd2);
    send_byte(8'h3C, 1'b1, 5'd3);
    chk("t2_flush", dbg_state, ST_FLUSH);
    step();
    chk("t2_run", dbg_state, ST_RUN);
    chk("t2_words4", words_loaded, 4);

    // 5a: timeout after TO RUN cycles
    repeat (TO - 1) step();
    chk("t5_before_to_state", dbg_state, ST_RUN);
    chk("t5_before_to_cycles", cycles, TO - 1);
    step();
    chk("t5_error", dbg_state, ST_ERROR);
    chk("t5_err_code", err_code, 2'b10);
    chk("t5_cpu_rst", cpu_rst, 1);
    chk("t5_cycles", cycles, TO - 1);
    chk("t5_error_out", error, 1);

    // 5b: halt on the timeout edge wins; load_start in RUN ignored
    start_load();
    chk("t5b_err_clr", err_code, 0);
    send_byte(8'hC5, 1'b1, 5'd0);
    step();
    chk("t5b_run", dbg_state, ST_RUN);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("t6_run_ls_ignored", dbg_state, ST_RUN);
    chk("t6_run_ls_cycles", cycles, 1);
    repeat (TO - 2) step();
    chk("t5b_cycles_last", cycles, TO - 1);
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    chk("t5b_halted", dbg_state, ST_HALTED);
    chk("t5b_err_none", err_code, 0);
    chk("t5b_cycles", cycles, TO - 1);

    // 3: overflow with 32 bytes and no in_last
    start_load();
    for (int i = 0; i < 31; i++) send_byte(DW'(8'h40 + i), 1'b0, AW'(i));
    chk("t3_load_31", dbg_state, ST_LOAD);
    chk("t3_words31", words_loaded, 31);
    send_byte(8'h5F, 1'b0, 5'd31);
    chk("t3_error", dbg_state, ST_ERROR);
    chk("t3_err_code", err_code, 2'b01);
    chk("t3_words32", words_loaded, 32);
    chk("t3_cpu_rst", cpu_rst, 1);
    chk("t3_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (3) step();
    in_valid = 1'b0;
    chk("t3_words_hold", words_loaded, 32);
    chk("t3_q_drained", exp_q.size(), 0);

    // 6: load_start in LOAD ignored, reset mid-load
    start_load();
    send_byte(8'hD0, 1'b0, 5'd0);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("t6_load_ls_words", words_loaded, 1);
    chk("t6_load_ls_state", dbg_state, ST_LOAD);
    send_byte(8'hD1, 1'b0, 5'd1);
    send_byte(8'hD2, 1'b0, 5'd2);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hD3;
    step();
    in_valid = 1'b0;
    chk("t6_idle", dbg_state, ST_IDLE);
    chk("t6_mem_wr", mem_wr, 0);
    chk("t6_words", words_loaded, 0);
    chk("t6_in_ready", in_ready, 0);
    rst = 1'b0;
    repeat (3) step();
    chk("t6_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
